// File: rtl/floppy_track_streamer.sv
// Streams one floppy track-side from the extra-ROM image at the disk byte rate.
// A single-entry prefetch buffer decouples ROM latency from byte emission.
module floppy_track_streamer #(
    parameter int unsigned BYTE_CYCLES  = 128,
    parameter int unsigned SECTOR_BYTES = 724,
    parameter int unsigned TRACK_STRIDE = 16384,
    parameter logic [21:0] IMAGE_BASE   = 22'h100000,
    parameter int unsigned THROTTLE     = 1
) (
    input  logic        clk8,
    input  logic        _reset,
    input  logic        _enable,
    input  logic        diskInDrive,
    input  logic [6:0]  track,
    input  logic        side,
    input  logic        advanceDriveHead,
    output logic [21:0] extraRomReadAddr,
    output logic        extraRomReadReq,
    input  logic        extraRomReadAck,
    input  logic [7:0]  extraRomReadData,
    output logic [7:0]  readData,
    output logic        newByteReady,
    output logic [13:0] trackPos
);

    localparam int unsigned TW = (BYTE_CYCLES > 32'd1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(BYTE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic logic [6:0] clamp_track(input logic [6:0] t);
        if (t > 7'd79) begin
            clamp_track = 7'd79;
        end else begin
            clamp_track = t;
        end
    endfunction

    // Zone band is track/16: 12 sectors in band 0 down to 8 in band 4.
    function automatic logic [13:0] track_len(input logic [2:0] band);
        logic [3:0] sectors;
        sectors   = 4'd12 - {1'b0, band};
        track_len = 14'(32'(sectors) * SECTOR_BYTES);
    endfunction

    function automatic logic [21:0] fetch_addr(input logic [7:0] ts, input logic [13:0] pos);
        fetch_addr = IMAGE_BASE + 22'(32'(ts) * TRACK_STRIDE) + {8'd0, pos};
    endfunction

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [21:0]     addr_q, addr_d;
    logic            discard_q, discard_d;
    logic [7:0]      buf_q, buf_d;
    logic [13:0]     buf_pos_q, buf_pos_d;
    logic [13:0]     fetch_pos_q, fetch_pos_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            adv_q, adv_d;
    logic            active_q;
    logic [7:0]      ts_q;
    logic [7:0]      rdata_q, rdata_d;
    logic            nbr_q, nbr_d;
    logic [13:0]     tpos_q, tpos_d;

    logic            active_s;
    logic [7:0]      ts_s;
    logic            chg_s;
    logic [13:0]     len_s;
    logic            capture_s;
    logic            throttle_ok_s;
    logic            emit_s;

    assign active_s      = ~_enable & diskInDrive;
    assign ts_s          = {clamp_track(track), side};
    assign chg_s         = (ts_s != ts_q);
    assign len_s         = track_len(ts_q[7:5]);
    assign capture_s     = (state_q == ST_FETCH) & extraRomReadAck & ~discard_q & ~chg_s & active_s;
    assign throttle_ok_s = (THROTTLE == 32'd0) | adv_q;
    assign emit_s        = active_s & (state_q == ST_FULL) & (timer_q == TW'(0)) & ~chg_s & throttle_ok_s;

    // Fetch FSM: an abandoned fetch still waits for its Ack, then drops the data.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        buf_d     = buf_q;
        buf_pos_d = buf_pos_q;
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (active_s && !chg_s) begin
                    state_d = ST_FETCH;
                    addr_d  = fetch_addr(ts_q, fetch_pos_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (chg_s || !active_s) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
                if (extraRomReadAck) begin
                    discard_d = 1'b0;
                    if (capture_s) begin
                        state_d   = ST_FULL;
                        buf_d     = extraRomReadData;
                        buf_pos_d = fetch_pos_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FULL: begin
                if (chg_s || emit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_FETCH);
    end

    // Position, byte timer and advance flag.
    always_comb begin
        fetch_pos_d = fetch_pos_q;
        timer_d     = timer_q;
        adv_d       = adv_q;
        if (chg_s) begin
            fetch_pos_d = 14'd0;
        end else if (capture_s) begin
            if (fetch_pos_q >= len_s - 14'd1) begin
                fetch_pos_d = 14'd0;
            end else begin
                fetch_pos_d = fetch_pos_q + 14'd1;
            end
        end else begin
            fetch_pos_d = fetch_pos_q;
        end

        if (chg_s || emit_s) begin
            timer_d = TIMER_LOAD;
        end else if (active_s && (timer_q != TW'(0))) begin
            timer_d = timer_q - TW'(1);
        end else begin
            timer_d = timer_q;
        end

        // A pulse coinciding with an emission is kept so no advance is lost.
        if (advanceDriveHead || (active_s && !active_q)) begin
            adv_d = 1'b1;
        end else if (emit_s) begin
            adv_d = 1'b0;
        end else begin
            adv_d = adv_q;
        end
    end

    // Consumer-facing outputs.
    always_comb begin
        nbr_d   = emit_s;
        rdata_d = rdata_q;
        tpos_d  = tpos_q;
        if (!diskInDrive) begin
            rdata_d = 8'd0;
        end else if (emit_s) begin
            rdata_d = buf_q;
        end else begin
            rdata_d = rdata_q;
        end
        if (emit_s) begin
            tpos_d = buf_pos_q;
        end else begin
            tpos_d = tpos_q;
        end
    end

    // State registers.
    always_ff @(posedge clk8 or negedge _reset) begin
        if (!_reset) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            addr_q      <= 22'd0;
            discard_q   <= 1'b0;
            buf_q       <= 8'd0;
            buf_pos_q   <= 14'd0;
            fetch_pos_q <= 14'd0;
            timer_q     <= TIMER_LOAD;
            adv_q       <= 1'b1;
            active_q    <= 1'b0;
            ts_q        <= 8'd0;
            rdata_q     <= 8'd0;
            nbr_q       <= 1'b0;
            tpos_q      <= 14'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            buf_q       <= buf_d;
            buf_pos_q   <= buf_pos_d;
            fetch_pos_q <= fetch_pos_d;
            timer_q     <= timer_d;
            adv_q       <= adv_d;
            active_q    <= active_s;
            ts_q        <= ts_s;
            rdata_q     <= rdata_d;
            nbr_q       <= nbr_d;
            tpos_q      <= tpos_d;
        end
    end

    assign extraRomReadAddr = addr_q;
    assign extraRomReadReq  = req_q;
    assign readData         = rdata_q;
    assign newByteReady     = nbr_q;
    assign trackPos         = tpos_q;

endmodule

// File: tb/tb_floppy_track_streamer.sv
// Directed bench for floppy_track_streamer with a latency-programmable ROM responder.
`timescale 1ns/1ps
module tb_floppy_track_streamer;

    localparam int BC = 8;

    logic        clk8 = 1'b0;
    logic        rst_n, en_n, disk, side, adv;
    logic [6:0]  trk;
    logic        ack_rom, ack_frc, ack;
    logic [7:0]  data_rom, data_frc, rom_data;
    logic [21:0] addr;
    logic        req, nbr;
    logic [7:0]  rdata;
    logic [13:0] tpos;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nbr_cnt = 0;
    int ack_lat = 2;
    int rom_cnt = 0;
    logic [21:0] last_ack_addr;

    assign ack      = ack_rom | ack_frc;
    assign rom_data = ack_frc ? data_frc : data_rom;

    floppy_track_streamer #(.BYTE_CYCLES(BC)) dut (
        .clk8(clk8), ._reset(rst_n), ._enable(en_n), .diskInDrive(disk),
        .track(trk), .side(side), .advanceDriveHead(adv),
        .extraRomReadAddr(addr), .extraRomReadReq(req),
        .extraRomReadAck(ack), .extraRomReadData(rom_data),
        .readData(rdata), .newByteReady(nbr), .trackPos(tpos)
    );

    always #5 clk8 = ~clk8;

    function automatic logic [7:0] rom_byte(input logic [21:0] a);
        return a[7:0] ^ a[21:14];
    endfunction

    function automatic logic [21:0] exp_addr(input int t, input int s, input int pos);
        int v;
        v = 32'h100000 + (t * 2 + s) * 16384 + pos;
        return v[21:0];
    endfunction

    initial forever begin
        @(posedge clk8);
        cyc++;
    end

    initial forever begin
        @(negedge clk8);
        if (nbr) nbr_cnt++;
    end

    // ROM model: Ack is a one-cycle pulse ack_lat cycles after Req is seen.
    initial begin
        ack_rom = 1'b0;
        data_rom = 8'h00;
        last_ack_addr = 22'h0;
        forever begin
            @(negedge clk8);
            if (ack_rom) begin
                ack_rom = 1'b0;
            end else if (req) begin
                rom_cnt++;
                if (rom_cnt >= ack_lat) begin
                    ack_rom = 1'b1;
                    data_rom = rom_byte(addr);
                    last_ack_addr = addr;
                    rom_cnt = 0;
                end
            end else begin
                rom_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk8);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_nbr(input int max, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!nbr && n < max);
        check({tag, "_seen"}, 32'(nbr), 32'd1);
    endtask

    task automatic wait_req(input int max, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!req && n < max);
        check({tag, "_req"}, 32'(req), 32'd1);
    endtask

    task automatic check_byte(input string tag, input int t, input int s, input int pos);
        check({tag, "_pos"}, 32'(tpos), 32'(pos));
        check({tag, "_data"}, 32'(rdata), 32'(rom_byte(exp_addr(t, s, pos))));
    endtask

    initial begin
        int c0, c_last, n0, errs, reqs, n;
        logic [13:0] pos_last, pos_wrap;
        rst_n = 1'b0; en_n = 1'b0; disk = 1'b1; trk = 7'd0; side = 1'b0;
        adv = 1'b1; ack_frc = 1'b0; data_frc = 8'h00;
        repeat (3) @(posedge clk8);
        #1;
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_nbr", 32'(nbr), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_tpos", 32'(tpos), 32'd0);

        // Basic streaming, track 0 side 0
        @(negedge clk8);
        rst_n = 1'b1;
        c0 = cyc;
        wait_req(10, "first");
        check("first_addr", 32'(addr), 32'(22'h100000));
        wait_nbr(40, "b0");
        check("b0_latency", 32'(cyc - c0), 32'(BC));
        check_byte("b0", 0, 0, 0);
        for (int p = 1; p < 4; p++) begin
            c_last = cyc;
            wait_nbr(40, "bn");
            check("bn_spacing", 32'(cyc - c_last), 32'(BC));
            check_byte("bn", 0, 0, p);
        end

        // Underrun: slow Ack stalls emission to the cycle after capture
        ack_lat = 20;
        for (int p = 4; p < 6; p++) begin
            c_last = cyc;
            wait_nbr(60, "slow");
            check("slow_spacing", 32'(cyc - c_last), 32'd22);
            check_byte("slow", 0, 0, p);
        end
        ack_lat = 2;
        c_last = cyc;
        wait_nbr(40, "fast");
        check("fast_spacing", 32'(cyc - c_last), 32'(BC));
        check_byte("fast", 0, 0, 6);

        // Throttle: the flag set by the held advance line releases one more byte
        adv = 1'b0;
        wait_nbr(40, "thr_left");
        check_byte("thr_left", 0, 0, 7);
        for (int k = 0; k < 2; k++) begin
            c_last = cyc;
            tick();
            n0 = nbr_cnt;
            repeat (30) tick();
            check("thr_idle", 32'(nbr_cnt - n0), 32'd0);
            adv = 1'b1;
            tick();
            adv = 1'b0;
            wait_nbr(5, "thr_pulse");
            check_byte("thr_pulse", 0, 0, 8 + k);
            check("thr_gap", 32'((cyc - c_last) >= 30), 32'd1);
        end
        tick();
        n0 = nbr_cnt;
        repeat (30) tick();
        check("thr_one_per_pulse", 32'(nbr_cnt - n0), 32'd0);
        adv = 1'b1;

        // Track 3, then switch to 4 while a fetch is outstanding
        trk = 7'd3;
        wait_nbr(60, "t3a");
        check_byte("t3a", 3, 0, 0);
        wait_nbr(40, "t3b");
        check_byte("t3b", 3, 0, 1);
        ack_lat = 20;
        wait_nbr(60, "t3c");
        check_byte("t3c", 3, 0, 2);
        wait_req(5, "t3d");
        trk = 7'd4;
        ack_lat = 2;
        wait_nbr(60, "t4a");
        check_byte("t4a", 4, 0, 0);
        check("t4a_ack_addr", 32'(last_ack_addr), 32'(22'h120000));

        // Disk removed mid-fetch
        wait_nbr(40, "t4b");
        check_byte("t4b", 4, 0, 1);
        ack_lat = 20;
        wait_nbr(60, "t4c");
        check_byte("t4c", 4, 0, 2);
        wait_req(5, "eject");
        disk = 1'b0;
        tick();
        check("eject_rdata", 32'(rdata), 32'd0);
        check("eject_req_pending", 32'(req), 32'd1);
        n = 0;
        while (req && n < 30) begin
            tick();
            n++;
        end
        check("eject_req_drop", 32'(req), 32'd0);
        tick();
        n0 = nbr_cnt;
        reqs = 0;
        repeat (40) begin
            tick();
            if (req) reqs++;
        end
        check("eject_no_req", 32'(reqs), 32'd0);
        check("eject_no_nbr", 32'(nbr_cnt - n0), 32'd0);
        check("eject_rdata_hold", 32'(rdata), 32'd0);
        disk = 1'b1;
        ack_lat = 2;
        wait_nbr(60, "reinsert");
        check_byte("reinsert", 4, 0, 3);

        // Track 70 side 1: full revolution and wrap
        trk = 7'd70;
        side = 1'b1;
        errs = 0;
        pos_last = 14'd0;
        pos_wrap = 14'd0;
        for (int i = 0; i <= 5792; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!nbr && n < 60);
            if (!nbr) begin
                errs++;
                break;
            end
            if (tpos !== 14'(i % 5792)) errs++;
            if (rdata !== rom_byte(exp_addr(70, 1, i % 5792))) errs++;
            if (i == 5791) pos_last = tpos;
            if (i == 5792) pos_wrap = tpos;
        end
        check("wrap_errs", 32'(errs), 32'd0);
        check("wrap_last", 32'(pos_last), 32'd5791);
        check("wrap_zero", 32'(pos_wrap), 32'd0);
        check("wrap_rdata", 32'(rdata), 32'(rom_byte(22'h334000)));

        // Reset during a fetch, then a stray Ack while idle
        ack_lat = 20;
        wait_nbr(60, "pre_rst");
        wait_req(5, "pre_rst");
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        check("mid_rst_tpos", 32'(tpos), 32'd0);
        en_n = 1'b1;
        @(negedge clk8);
        rst_n = 1'b1;
        tick();
        ack_frc = 1'b1;
        data_frc = 8'hAA;
        tick();
        ack_frc = 1'b0;
        check("late_ack_req", 32'(req), 32'd0);
        en_n = 1'b0;
        ack_lat = 2;
        wait_nbr(60, "post_rst");
        check_byte("post_rst", 70, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
